// File: rtl/dh_privkey_gen.sv
// dh_privkey_gen: draws Diffie-Hellman private exponents in [2, prime-2] by rejection sampling a Galois LFSR.
// Optional macro DH_RETRY_LIMIT_EN caps the rejected candidates per request at MAX_RETRY and flags err instead.
module dh_privkey_gen #(
    parameter int               WIDTH     = 100,
    parameter logic [WIDTH-1:0] TAPS      = 100'h8_0000_0000_0000_0001_0000_0000,
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
    parameter int               MAX_RETRY = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [WIDTH-1:0] prime,
    input  logic             req,
    output logic [WIDTH:0]   exp_out,
    output logic             exp_valid,
    input  logic             exp_ready,
    output logic             exp_start,
    output logic             busy,
    output logic             err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        CHECK,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_step;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] prime_q;
    logic [WIDTH-1:0] prime_m2;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]    bit_cnt;
    logic [RW-1:0]    retry_cnt;
    logic             seen;
    logic             gen_done;
    logic             prime_small;
    logic             in_range;
    logic             retry_hit;

    assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);

    // Mask keeps candidate bits up to the MSB of the modulus so most draws land near the range.
    always_comb begin
        mask = '0;
        seen = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            seen    = seen | prime_q[i];
            mask[i] = seen;
        end
    end

    assign m           = cand & mask;
    assign prime_m2    = prime_q - WIDTH'(2);
    assign prime_small = prime_q < WIDTH'(5);
    assign in_range    = (m >= WIDTH'(2)) && (m <= prime_m2);
    assign gen_done    = bit_cnt == CW'(WIDTH - 1);

`ifdef DH_RETRY_LIMIT_EN
    assign retry_hit = (int'(retry_cnt) + 1) >= MAX_RETRY;
`else
    assign retry_hit = 1'b0;
`endif

    assign exp_start = (state == HOLD) && exp_ready;
    assign busy      = state != IDLE;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = GEN;
                end
            end
            GEN: begin
                if (gen_done) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (prime_small) begin
                    state_next = IDLE;
                end else if (in_range) begin
                    state_next = HOLD;
                end else if (retry_hit) begin
                    state_next = IDLE;
                end else begin
                    state_next = GEN;
                end
            end
            HOLD: begin
                if (exp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The LFSR only advances in GEN, so each seed yields a reproducible exponent sequence.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr      <= SEED;
            cand      <= '0;
            prime_q   <= '0;
            bit_cnt   <= '0;
            retry_cnt <= '0;
            exp_out   <= '0;
            exp_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (seed_load) begin
                        lfsr <= (seed_in == '0) ? SEED : seed_in;
                    end
                    if (req) begin
                        prime_q   <= prime;
                        err       <= 1'b0;
                        retry_cnt <= '0;
                    end
                end
                GEN: begin
                    lfsr    <= lfsr_step;
                    cand    <= {cand[WIDTH-2:0], lfsr[0]};
                    bit_cnt <= gen_done ? '0 : bit_cnt + CW'(1);
                end
                CHECK: begin
                    if (prime_small) begin
                        err <= 1'b1;
                    end else if (in_range) begin
                        exp_out   <= {1'b0, m};
                        exp_valid <= 1'b1;
                    end else begin
                        retry_cnt <= retry_cnt + RW'(1);
                        if (retry_hit) begin
                            err <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (exp_ready) begin
                        exp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dh_privkey_gen.sv
// tb_dh_privkey_gen: directed scoreboard bench for dh_privkey_gen at WIDTH=8, TAPS=8'hB8, SEED=8'h01.
// Expected exponents are hand-derived from the LFSR sequence; a monitor pops them on each handshake.
module tb_dh_privkey_gen;

    localparam int W    = 8;
    localparam int MAXR = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         seed_load;
    logic [W-1:0] seed_in;
    logic [W-1:0] prime;
    logic         req;
    logic [W:0]   exp_out;
    logic         exp_valid;
    logic         exp_ready;
    logic         exp_start;
    logic         busy;
    logic         err;

    int         total = 0;
    int         bad = 0;
    int         start_cnt = 0;
    logic [W:0] exp_q[$];
    logic [W:0] mon_exp;

    dh_privkey_gen #(
        .WIDTH(W),
        .TAPS(8'hB8),
        .SEED(8'h01),
        .MAX_RETRY(MAXR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .seed_load(seed_load),
        .seed_in(seed_in),
        .prime(prime),
        .req(req),
        .exp_out(exp_out),
        .exp_valid(exp_valid),
        .exp_ready(exp_ready),
        .exp_start(exp_start),
        .busy(busy),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        req = 1'b0;
        seed_load = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    task automatic applyStimulus(input logic [W-1:0] p, input bit load, input logic [W-1:0] seed);
        prime     = p;
        seed_load = load;
        seed_in   = seed;
        req       = 1'b1;
        tick(1);
        req       = 1'b0;
        seed_load = 1'b0;
    endtask

    // Counts falling edges until exp_valid (or err) is seen; an expired budget is a failure.
    task automatic waitFor(input bit want_err, input int budget, input string tag, output int n);
        n = 0;
        while (!(want_err ? err : exp_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!(want_err ? err : exp_valid)) begin
            bad++;
            $display("[TB] FAIL %s_timeout: actual=no event required=event within %0d cycles", tag, budget);
        end
    endtask

    task automatic runTxn(input logic [W-1:0] p, input bit load, input logic [W-1:0] seed,
                          input logic [W:0] expv, input int lat, input string tag);
        int n;
        int sc;
        exp_q.push_back(expv);
        sc = start_cnt;
        applyStimulus(p, load, seed);
        checkOutput({tag, "_busy_after_req"}, busy, 1);
        checkOutput({tag, "_err_cleared"}, err, 0);
        waitFor(1'b0, 60, tag, n);
        checkOutput({tag, "_latency"}, n, lat);
        tick(1);
        checkOutput({tag, "_busy_done"}, busy, 0);
        checkOutput({tag, "_valid_done"}, exp_valid, 0);
        checkOutput({tag, "_start_pulses"}, start_cnt - sc, 1);
    endtask

    function automatic void model_gen(input logic [W-1:0] seed, input logic [W-1:0] p, input int limit,
                                      output logic [W:0] val, output int attempts, output bit e);
        logic [W-1:0] l;
        logic [W-1:0] c;
        logic [W-1:0] msk;
        l = seed;
        val = '0;
        attempts = 0;
        e = 1'b0;
        msk = '0;
        for (int i = 0; i < W; i++) begin
            if ((p >> i) != 0) msk[i] = 1'b1;
        end
        for (int a = 1; a <= 200; a++) begin
            c = '0;
            for (int k = 0; k < W; k++) begin
                c = {c[W-2:0], l[0]};
                l = l[0] ? ((l >> 1) ^ 8'hB8) : (l >> 1);
            end
            attempts = a;
            c = c & msk;
            if (int'(c) >= 2 && int'(c) <= int'(p) - 2) begin
                val = {1'b0, c};
                return;
            end
            if (limit != 0 && a >= limit) begin
                e = 1'b1;
                return;
            end
        end
        e = 1'b1;
    endfunction

    // Scoreboard monitor: every handshake must match the oldest expected exponent.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (exp_start) start_cnt++;
            if (exp_valid && exp_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_exp: actual=%0d required=no output", exp_out);
                end else begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("exp_out", exp_out, mon_exp);
                    checkOutput("exp_start_on_handshake", exp_start, 1);
                end
            end else if (exp_start) begin
                checkOutput("stray_exp_start", exp_start, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int sc;
        int limit;
        int ma;
        bit me;
        logic [W:0] mv;

        rst = 1'b0;
        seed_load = 1'b0;
        seed_in = '0;
        prime = 8'd23;
        req = 1'b0;
        exp_ready = 1'b1;
        tick(2);
        checkOutput("reset_exp_out", exp_out, 0);
        checkOutput("reset_exp_valid", exp_valid, 0);
        checkOutput("reset_exp_start", exp_start, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_err", err, 0);
        rst = 1'b1;
        tick(1);

        $display("[TB] scenario 1: back-to-back requests from SEED, prime=23");
        runTxn(8'd23, 1'b0, 8'h00, 9'd14, 10, "s1a");
        runTxn(8'd23, 1'b0, 8'h00, 9'd5, 10, "s1b");
        runTxn(8'd23, 1'b0, 8'h00, 9'd9, 19, "s1c");

        $display("[TB] scenario 2: prime=3 sets err, next valid request clears it");
        applyStimulus(8'd3, 1'b0, 8'h00);
        waitFor(1'b1, 40, "s2", n);
        checkOutput("s2_err_latency", n, 10);
        tick(1);
        checkOutput("s2_busy", busy, 0);
        checkOutput("s2_valid", exp_valid, 0);
        tick(3);
        checkOutput("s2_err_sticky", err, 1);
        runTxn(8'd23, 1'b0, 8'h00, 9'd13, 19, "s2b");

        $display("[TB] scenario 3: exp_ready held low for 20 cycles");
        doReset();
        exp_ready = 1'b0;
        exp_q.push_back(9'd14);
        sc = start_cnt;
        applyStimulus(8'd23, 1'b0, 8'h00);
        waitFor(1'b0, 40, "s3", n);
        checkOutput("s3_latency", n, 10);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("s3_hold_exp_out", exp_out, 14);
            checkOutput("s3_hold_valid", exp_valid, 1);
            checkOutput("s3_hold_start", exp_start, 0);
        end
        tick(1);
        exp_ready = 1'b1;
        @(negedge clk);
        tick(1);
        checkOutput("s3_valid_dropped", exp_valid, 0);
        checkOutput("s3_busy", busy, 0);
        checkOutput("s3_start_pulses", start_cnt - sc, 1);
        runTxn(8'd23, 1'b0, 8'h00, 9'd5, 10, "s3b");

        $display("[TB] scenario 4: zero seed reloads SEED, repeatable across reset");
        runTxn(8'd23, 1'b1, 8'h00, 9'd14, 10, "s4a");
        doReset();
        runTxn(8'd23, 1'b1, 8'h00, 9'd14, 10, "s4b");
        runTxn(8'd23, 1'b1, 8'h05, 9'd13, 10, "s4c");

        $display("[TB] scenario 5: reset mid-GEN abandons the attempt");
        doReset();
        applyStimulus(8'd23, 1'b0, 8'h00);
        tick(4);
        checkOutput("s5_busy_in_gen", busy, 1);
        rst = 1'b0;
        tick(1);
        checkOutput("s5_exp_out", exp_out, 0);
        checkOutput("s5_exp_valid", exp_valid, 0);
        checkOutput("s5_exp_start", exp_start, 0);
        checkOutput("s5_busy", busy, 0);
        checkOutput("s5_err", err, 0);
        rst = 1'b1;
        tick(1);
        exp_q.push_back(9'd14);
        sc = start_cnt;
        applyStimulus(8'd23, 1'b0, 8'h00);
        tick(3);
        prime = 8'd3;
        req = 1'b1;
        tick(1);
        req = 1'b0;
        prime = 8'd23;
        waitFor(1'b0, 40, "s5", n);
        checkOutput("s5_latency_after_stray_req", n, 6);
        tick(1);
        checkOutput("s5_err_after_stray", err, 0);
        checkOutput("s5_busy_done", busy, 0);
        checkOutput("s5_start_pulses", start_cnt - sc, 1);

        $display("[TB] scenario 6: prime=5 with first candidate rejected");
`ifdef DH_RETRY_LIMIT_EN
        limit = MAXR;
`else
        limit = 0;
`endif
        doReset();
        model_gen(8'h01, 8'd5, limit, mv, ma, me);
        sc = start_cnt;
        if (!me) exp_q.push_back(mv);
        applyStimulus(8'd5, 1'b0, 8'h00);
        waitFor(me, 9 * ma + 20, "s6", n);
        checkOutput("s6_latency", n, 9 * ma + 1);
        tick(1);
        checkOutput("s6_err", err, me);
        checkOutput("s6_busy", busy, 0);
        checkOutput("s6_start_pulses", start_cnt - sc, me ? 0 : 1);

        tick(2);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
